// File: rtl/wb_arbiter_pkg.sv
// Shared types and widths for the write-back arbiter: result entry layout and source ids.
package wb_pkg;
    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wb_entry_t;

    typedef enum logic {
        WB_SRC_ALU = 1'b0,
        WB_SRC_LSU = 1'b1
    } wb_src_e;
endpackage

// File: rtl/wb_arbiter_fifo.sv
// Per-source result FIFO; DEPTH must be a power of two so pointers wrap by overflow.
module wb_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic      clk_i,
    input  logic      reset_i,
    input  logic      push_i,
    input  wb_entry_t push_data_i,
    input  logic      pop_i,
    output wb_entry_t pop_data_o,
    output logic      full_o,
    output logic      empty_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    wb_entry_t        mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    assign full_o     = (count_q == CNT_W'(DEPTH));
    assign empty_o    = (count_q == '0);
    assign push_ok    = push_i && !full_o;
    assign pop_ok     = pop_i && !empty_o;
    assign pop_data_o = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = push_ok ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop_ok  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q;
        if (push_ok && !pop_ok) begin
            count_d = count_q + CNT_W'(1);
        end else if (!push_ok && pop_ok) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is left uncleared by reset; the pointers alone define what is valid.
    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end
endmodule

// File: rtl/wb_arbiter.sv
// Round-robin write-back arbiter merging ALU and LSU results into one register-file port.
// Optional macro WB_BYPASS_EN adds a combinational forwarding port off the write stage.
module wb_arbiter
    import wb_pkg::*;
#(
    parameter int FIFO_DEPTH = 2
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        alu_valid_i,
    output logic        alu_ready_o,
    input  logic [4:0]  alu_rd_i,
    input  logic [31:0] alu_data_i,
    input  logic        lsu_valid_i,
    output logic        lsu_ready_o,
    input  logic [4:0]  lsu_rd_i,
    input  logic [31:0] lsu_data_i,
    output logic        rf_write_en_o,
    output logic [4:0]  rf_write_addr_o,
    output logic [31:0] rf_write_data_o,
    output logic        busy_o
`ifdef WB_BYPASS_EN
    ,
    input  logic [4:0]  byp_addr_i,
    output logic        byp_hit_o,
    output logic [31:0] byp_data_o
`endif
);
    logic      src_valid [2];
    wb_entry_t src_in    [2];
    wb_entry_t src_head  [2];
    logic      src_full  [2];
    logic      src_empty [2];
    logic      src_pop   [2];

    logic      grant_valid;
    wb_src_e   grant_src;
    wb_src_e   last_q, last_d;
    logic      out_valid_q, out_valid_d;
    wb_entry_t out_entry_q, out_entry_d;

    assign src_valid[WB_SRC_ALU] = alu_valid_i;
    assign src_valid[WB_SRC_LSU] = lsu_valid_i;
    assign src_in[WB_SRC_ALU]    = '{rd: alu_rd_i, data: alu_data_i};
    assign src_in[WB_SRC_LSU]    = '{rd: lsu_rd_i, data: lsu_data_i};

    for (genvar gi = 0; gi < 2; gi++) begin : g_src
        wb_fifo #(
            .DEPTH(FIFO_DEPTH)
        ) u_fifo (
            .clk_i      (clk_i),
            .reset_i    (reset_i),
            .push_i     (src_valid[gi] && !src_full[gi]),
            .push_data_i(src_in[gi]),
            .pop_i      (src_pop[gi]),
            .pop_data_o (src_head[gi]),
            .full_o     (src_full[gi]),
            .empty_o    (src_empty[gi])
        );
        assign src_pop[gi] = grant_valid && (int'(grant_src) == gi);
    end

    // Ready comes from registered occupancy, so a full FIFO stays blocked even while popping.
    assign alu_ready_o = !src_full[WB_SRC_ALU];
    assign lsu_ready_o = !src_full[WB_SRC_LSU];

    always_comb begin
        grant_valid = 1'b0;
        grant_src   = WB_SRC_ALU;
        if (!src_empty[WB_SRC_ALU] && !src_empty[WB_SRC_LSU]) begin
            grant_valid = 1'b1;
            grant_src   = (last_q == WB_SRC_ALU) ? WB_SRC_LSU : WB_SRC_ALU;
        end else if (!src_empty[WB_SRC_ALU]) begin
            grant_valid = 1'b1;
            grant_src   = WB_SRC_ALU;
        end else if (!src_empty[WB_SRC_LSU]) begin
            grant_valid = 1'b1;
            grant_src   = WB_SRC_LSU;
        end
    end

    always_comb begin
        out_valid_d = grant_valid;
        out_entry_d = grant_valid ? src_head[grant_src] : out_entry_q;
        last_d      = grant_valid ? grant_src : last_q;
    end

    // Last-grant resets to ALU so the LSU wins the first contention.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            out_valid_q <= 1'b0;
            out_entry_q <= '0;
            last_q      <= WB_SRC_ALU;
        end else begin
            out_valid_q <= out_valid_d;
            out_entry_q <= out_entry_d;
            last_q      <= last_d;
        end
    end

    // x0 entries travel through the output stage but never assert the write.
    assign rf_write_en_o   = out_valid_q && (out_entry_q.rd != '0);
    assign rf_write_addr_o = rf_write_en_o ? out_entry_q.rd   : '0;
    assign rf_write_data_o = rf_write_en_o ? out_entry_q.data : '0;
    assign busy_o          = !src_empty[WB_SRC_ALU] || !src_empty[WB_SRC_LSU] || out_valid_q;

`ifdef WB_BYPASS_EN
    assign byp_hit_o  = rf_write_en_o && (byp_addr_i == rf_write_addr_o);
    assign byp_data_o = byp_hit_o ? rf_write_data_o : '0;
`endif
endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter with a per-source in-order scoreboard on register-file writes.
module tb_wb_arbiter;
    logic        clk;
    logic        reset;
    logic        alu_valid, alu_ready;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        lsu_valid, lsu_ready;
    logic [4:0]  lsu_rd;
    logic [31:0] lsu_data;
    logic        rf_en;
    logic [4:0]  rf_addr;
    logic [31:0] rf_data;
    logic        busy;
`ifdef WB_BYPASS_EN
    logic [4:0]  byp_addr;
    logic        byp_hit;
    logic [31:0] byp_data;
`endif

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } exp_t;

    exp_t alu_q[$];
    exp_t lsu_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   alu_stall = 0;
    logic alu_acc, lsu_acc;

    wb_arbiter #(.FIFO_DEPTH(2)) dut (
        .clk_i          (clk),
        .reset_i        (reset),
        .alu_valid_i    (alu_valid),
        .alu_ready_o    (alu_ready),
        .alu_rd_i       (alu_rd),
        .alu_data_i     (alu_data),
        .lsu_valid_i    (lsu_valid),
        .lsu_ready_o    (lsu_ready),
        .lsu_rd_i       (lsu_rd),
        .lsu_data_i     (lsu_data),
        .rf_write_en_o  (rf_en),
        .rf_write_addr_o(rf_addr),
        .rf_write_data_o(rf_data),
        .busy_o         (busy)
`ifdef WB_BYPASS_EN
        ,
        .byp_addr_i     (byp_addr),
        .byp_hit_o      (byp_hit),
        .byp_data_o     (byp_data)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: record handshakes before the edge, then score any write after it.
    task automatic step();
        alu_acc = alu_valid && alu_ready;
        lsu_acc = lsu_valid && lsu_ready;
        if (alu_valid && !alu_ready) alu_stall++;
        if (reset) begin
            alu_q.delete();
            lsu_q.delete();
        end else begin
            if (alu_acc && alu_rd != 5'd0) alu_q.push_back('{rd: alu_rd, data: alu_data});
            if (lsu_acc && lsu_rd != 5'd0) lsu_q.push_back('{rd: lsu_rd, data: lsu_data});
        end
        @(posedge clk);
        #1;
        if (rf_en) begin
            if (alu_q.size() > 0 && alu_q[0].data === rf_data) begin
                chk("sb_alu_rd", rf_addr, alu_q[0].rd);
                void'(alu_q.pop_front());
            end else if (lsu_q.size() > 0 && lsu_q[0].data === rf_data) begin
                chk("sb_lsu_rd", rf_addr, lsu_q[0].rd);
                void'(lsu_q.pop_front());
            end else if (alu_q.size() > 0) begin
                chk("sb_alu_data", rf_data, alu_q[0].data);
                void'(alu_q.pop_front());
            end else if (lsu_q.size() > 0) begin
                chk("sb_lsu_data", rf_data, lsu_q[0].data);
                void'(lsu_q.pop_front());
            end else begin
                chk("sb_write_without_entry", rf_en, 1'b0);
            end
            $display("write rd=%0d data=%08h t=%0t", rf_addr, rf_data, $time);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_en"}, rf_en, 1'b0);
        chk({tag, "_addr"}, rf_addr, 5'd0);
        chk({tag, "_data"}, rf_data, 32'd0);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_alu_rdy"}, alu_ready, 1'b1);
        chk({tag, "_lsu_rdy"}, lsu_ready, 1'b1);
    endtask

    initial begin
        int li;
        int ai;
        reset = 1'b1;
        alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
        lsu_valid = 1'b0; lsu_rd = '0; lsu_data = '0;
`ifdef WB_BYPASS_EN
        byp_addr = '0;
`endif
        step();
        step();
        chk_idle("in_reset");
        reset = 1'b0;
        step();
        chk_idle("post_reset");

        // Single ALU write: visible exactly two cycles after the handshake.
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
        step();
        alu_valid = 1'b0;
        chk("single_c1_en", rf_en, 1'b0);
        chk("single_c1_busy", busy, 1'b1);
        step();
        chk("single_c2_en", rf_en, 1'b1);
        chk("single_c2_addr", rf_addr, 5'd5);
        chk("single_c2_data", rf_data, 32'hDEADBEEF);
        step();
        chk("single_c3_en", rf_en, 1'b0);
        chk("single_c3_busy", busy, 1'b0);

        // Simultaneous pushes: LSU wins first contention after reset.
        alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'h11;
        lsu_valid = 1'b1; lsu_rd = 5'd2; lsu_data = 32'h22;
        step();
        alu_valid = 1'b0; lsu_valid = 1'b0;
        chk("contend_c1_en", rf_en, 1'b0);
        step();
        chk("contend_c2_en", rf_en, 1'b1);
        chk("contend_c2_addr", rf_addr, 5'd2);
        chk("contend_c2_data", rf_data, 32'h22);
        step();
        chk("contend_c3_en", rf_en, 1'b1);
        chk("contend_c3_addr", rf_addr, 5'd1);
        chk("contend_c3_data", rf_data, 32'h11);
        step();
        chk("contend_c4_en", rf_en, 1'b0);

        // x0 destination: occupies the pipe but never writes.
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h1234;
        step();
        alu_valid = 1'b0;
        chk("x0_c1_busy", busy, 1'b1);
        chk("x0_c1_en", rf_en, 1'b0);
        step();
        chk("x0_c2_busy", busy, 1'b1);
        chk("x0_c2_en", rf_en, 1'b0);
        step();
        chk("x0_c3_busy", busy, 1'b0);
        chk("x0_c3_en", rf_en, 1'b0);

        // Continuous LSU stream, then a 4-entry ALU burst that must see backpressure.
        li = 0;
        ai = 0;
        alu_stall = 0;
        for (int c = 0; c < 48; c++) begin
            lsu_valid = (li < 14);
            lsu_rd    = 5'(li + 1);
            lsu_data  = 32'hB000_0000 + 32'(li);
            alu_valid = (c >= 6) && (ai < 4);
            alu_rd    = 5'(10 + ai);
            alu_data  = 32'hA000_0000 + 32'(ai);
            step();
            if (lsu_acc) li++;
            if (alu_acc) ai++;
            if (c >= 1 && c <= 8) chk("throughput_en", rf_en, 1'b1);
        end
        alu_valid = 1'b0; lsu_valid = 1'b0;
        chk("burst_alu_backpressure", alu_stall > 0, 1'b1);
        chk("burst_alu_accepted", 32'(ai), 32'd4);
        chk("burst_lsu_accepted", 32'(li), 32'd14);
        chk("burst_alu_drained", 32'(alu_q.size()), 32'd0);
        chk("burst_lsu_drained", 32'(lsu_q.size()), 32'd0);
        chk("burst_busy", busy, 1'b0);

        // Reset with two entries buffered: nothing may be written afterwards.
        alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'hA1;
        lsu_valid = 1'b1; lsu_rd = 5'd4; lsu_data = 32'hB1;
        step();
        alu_valid = 1'b0; lsu_valid = 1'b0;
        chk("prereset_busy", busy, 1'b1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk_idle("midreset");
        for (int c = 0; c < 3; c++) begin
            step();
            chk("midreset_no_write", rf_en, 1'b0);
        end

`ifdef WB_BYPASS_EN
        alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'hCAFE0000;
        byp_addr = 5'd7;
        step();
        alu_valid = 1'b0;
        step();
        chk("byp_hit", byp_hit, 1'b1);
        chk("byp_data", byp_data, 32'hCAFE0000);
        byp_addr = 5'd8;
        #1;
        chk("byp_miss_hit", byp_hit, 1'b0);
        chk("byp_miss_data", byp_data, 32'd0);
        step();
        chk("byp_idle_hit", byp_hit, 1'b0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
